// File: rtl/array_rd_pkg.sv
// Shared types and sizing helpers for the array row reader.
// Package defaults set the nominal geometry; the top may override per instance.
package array_rd_pkg;

  localparam int NROWS_DEF = 2;
  localparam int NCOLS_DEF = 2;
  localparam int NBITS_DEF = 16;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

  typedef logic signed [NBITS_DEF-1:0] elem_t;
  typedef elem_t [NCOLS_DEF-1:0]       row_t;

  // Index width never drops below one bit, so a single-row array still has a ROW_IDX.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int IDX_W_DEF = idx_w(NROWS_DEF);

endpackage

// File: rtl/array_row_mux.sv
// Combinational row selector: picks row sel out of a packed NROWS x NCOLS array.
module array_row_mux
  import array_rd_pkg::*;
#(
  parameter int NROWS = NROWS_DEF,
  parameter int NCOLS = NCOLS_DEF,
  parameter int NBITS = NBITS_DEF,
  parameter int IW    = idx_w(NROWS)
) (
  input  logic [NROWS-1:0][NCOLS-1:0][NBITS-1:0] src,
  input  logic [IW-1:0]                          sel,
  output logic [NCOLS-1:0][NBITS-1:0]            row
);

  assign row = src[sel];

endmodule

// File: rtl/array_row_reader.sv
// Captures a 2D array on START and streams it out one row per valid/ready handshake.
// state  | meaning
// IDLE   | waiting for START; outputs quiet
// STREAM | ROW_VALID held high, advancing one row per accepted handshake
module array_row_reader
  import array_rd_pkg::*;
#(
  parameter  int NROWS = NROWS_DEF,
  parameter  int NCOLS = NCOLS_DEF,
  parameter  int NBITS = NBITS_DEF,
  localparam int IW    = idx_w(NROWS)
) (
  input  logic                                   CLK,
  input  logic                                   RST,
  input  logic                                   START,
  input  logic                                   REVERSE,
  input  logic [NROWS-1:0][NCOLS-1:0][NBITS-1:0] A,
  output logic [NCOLS-1:0][NBITS-1:0]            ROW,
  output logic [IW-1:0]                          ROW_IDX,
  output logic                                   ROW_VALID,
  input  logic                                   ROW_READY,
  output logic                                   ROW_LAST,
  output logic                                   BUSY,
  output logic                                   DONE
);

  localparam logic [IW-1:0] LAST_FWD = IW'(NROWS - 1);

  state_e                                 state;
  logic                                   rev_q;
  logic [IW-1:0]                          ptr;
  logic [IW-1:0]                          nxt_ptr;
  logic [NROWS-1:0][NCOLS-1:0][NBITS-1:0] buf_q;
  logic [NROWS-1:0][NCOLS-1:0][NBITS-1:0] src;
  logic [NCOLS-1:0][NBITS-1:0]            mux_row;
  logic                                   take;
  logic                                   hs;
  logic                                   at_final;
  logic                                   nxt_last;

  function automatic logic is_final(input logic [IW-1:0] p, input logic rev);
    return rev ? (p == '0) : (p == LAST_FWD);
  endfunction

  always_comb begin
    take     = (state == IDLE) && START;
    hs       = (state == STREAM) && ROW_VALID && ROW_READY;
    at_final = is_final(ptr, rev_q);
    nxt_ptr  = ptr;
    if (take)
      nxt_ptr = REVERSE ? LAST_FWD : '0;
    else if (hs && !at_final)
      nxt_ptr = rev_q ? (ptr - IW'(1)) : (ptr + IW'(1));
    nxt_last = is_final(nxt_ptr, take ? REVERSE : rev_q);
    // The first row comes straight from A because the snapshot lands on the same edge.
    src      = take ? A : buf_q;
  end

  array_row_mux #(
    .NROWS (NROWS),
    .NCOLS (NCOLS),
    .NBITS (NBITS),
    .IW    (IW)
  ) u_mux (
    .src (src),
    .sel (nxt_ptr),
    .row (mux_row)
  );

  always_ff @(posedge CLK) begin
    if (take)
      buf_q <= A;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      rev_q     <= 1'b0;
      ptr       <= '0;
      ROW       <= '0;
      ROW_VALID <= 1'b0;
      ROW_LAST  <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (take) begin
            rev_q     <= REVERSE;
            ptr       <= nxt_ptr;
            ROW       <= mux_row;
            ROW_VALID <= 1'b1;
            ROW_LAST  <= nxt_last;
            BUSY      <= 1'b1;
            state     <= STREAM;
          end
        end
        STREAM: begin
          if (hs) begin
            if (at_final) begin
              ROW_VALID <= 1'b0;
              ROW_LAST  <= 1'b0;
              BUSY      <= 1'b0;
              DONE      <= 1'b1;
              state     <= IDLE;
            end else begin
              ptr      <= nxt_ptr;
              ROW      <= mux_row;
              ROW_LAST <= nxt_last;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ROW_IDX = ptr;

endmodule

// File: tb/tb_array_row_reader.sv
// Scoreboarded bench for array_row_reader: 2x2x16 instance plus a 1x3x8 edge instance.
module tb_array_row_reader;

  typedef struct {
    logic [31:0] row;
    logic        idx;
    logic        last;
  } exp_t;

  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  logic                    start = 1'b0, rev = 1'b0, ready = 1'b0;
  logic [1:0][1:0][15:0]   a = '0;
  logic [1:0][15:0]        row;
  logic [0:0]              idx;
  logic                    valid, last, busy, done;

  logic                    e_start = 1'b0, e_rev = 1'b0, e_ready = 1'b0;
  logic [0:0][2:0][7:0]    e_a = '0;
  logic [2:0][7:0]         e_row;
  logic [0:0]              e_idx;
  logic                    e_valid, e_last, e_busy, e_done;

  int   total = 0;
  int   bad = 0;
  exp_t sb[$];
  logic m_busy = 1'b0;
  logic exp_done = 1'b0;
  int   m_left = 0;

  always #5 clk = ~clk;

  array_row_reader #(.NROWS(2), .NCOLS(2), .NBITS(16)) dut (
    .CLK(clk), .RST(rst), .START(start), .REVERSE(rev), .A(a),
    .ROW(row), .ROW_IDX(idx), .ROW_VALID(valid), .ROW_READY(ready),
    .ROW_LAST(last), .BUSY(busy), .DONE(done)
  );

  array_row_reader #(.NROWS(1), .NCOLS(3), .NBITS(8)) dut_e (
    .CLK(clk), .RST(rst), .START(e_start), .REVERSE(e_rev), .A(e_a),
    .ROW(e_row), .ROW_IDX(e_idx), .ROW_VALID(e_valid), .ROW_READY(e_ready),
    .ROW_LAST(e_last), .BUSY(e_busy), .DONE(e_done)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a stream is a list of rows in emit order; it drains one per accepted cycle.
  always @(posedge rst) begin
    sb.delete();
    m_busy   = 1'b0;
    exp_done = 1'b0;
    m_left   = 0;
  end

  always @(posedge clk) begin
    if (!rst) begin
      exp_done = 1'b0;
      if (m_busy) begin
        if (ready) begin
          m_left--;
          if (m_left == 0) begin
            m_busy   = 1'b0;
            exp_done = 1'b1;
          end
        end
      end else if (start) begin
        for (int i = 0; i < 2; i++) begin
          exp_t e;
          int   r;
          r      = rev ? (1 - i) : i;
          e.row  = a[r];
          e.idx  = r[0];
          e.last = (i == 1);
          sb.push_back(e);
        end
        m_busy = 1'b1;
        m_left = 2;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("valid", 64'(valid), 64'(m_busy));
      chk("busy", 64'(busy), 64'(m_busy));
      chk("done", 64'(done), 64'(exp_done));
      if (valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_row", 64'(1), 64'(0));
        end else begin
          exp_t e;
          e = sb[0];
          chk("row", 64'(row), 64'(e.row));
          chk("row_idx", 64'(idx), 64'(e.idx));
          chk("row_last", 64'(last), 64'(e.last));
          if (ready) e = sb.pop_front();
        end
      end
    end
  end

  task automatic drain();
    start = 1'b0;
    ready = 1'b1;
    for (int i = 0; i < 20 && m_busy; i++) step();
    step();
    chk("drain_busy", 64'(m_busy), 64'(0));
    chk("drain_queue", 64'(sb.size()), 64'(0));
  endtask

  task automatic load_base();
    a[0][0] = 16'd1; a[0][1] = 16'd2;
    a[1][0] = 16'd3; a[1][1] = 16'd4;
  endtask

  initial begin
    #2 rst = 1'b1;
    #1;
    chk("rst_row", 64'(row), 64'(0));
    chk("rst_idx", 64'(idx), 64'(0));
    chk("rst_valid", 64'(valid), 64'(0));
    chk("rst_last", 64'(last), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    step(); step();
    rst = 1'b0;
    step();

    // forward, ready held high
    load_base();
    ready = 1'b1; rev = 1'b0; start = 1'b1;
    step(); start = 1'b0;
    chk("fwd_row0", 64'(row), 64'h0002_0001);
    chk("fwd_idx0", 64'(idx), 64'(0));
    chk("fwd_last0", 64'(last), 64'(0));
    step();
    chk("fwd_row1", 64'(row), 64'h0004_0003);
    chk("fwd_last1", 64'(last), 64'(1));
    step();
    chk("fwd_done", 64'(done), 64'(1));
    chk("fwd_valid_off", 64'(valid), 64'(0));
    step();
    chk("fwd_done_pulse", 64'(done), 64'(0));

    // reverse
    rev = 1'b1; start = 1'b1;
    step(); start = 1'b0; rev = 1'b0;
    chk("rev_row0", 64'(row), 64'h0004_0003);
    chk("rev_idx0", 64'(idx), 64'(1));
    step();
    chk("rev_row1", 64'(row), 64'h0002_0001);
    chk("rev_last1", 64'(last), 64'(1));
    drain();

    // backpressure on row 0
    ready = 1'b0; start = 1'b1;
    step(); start = 1'b0;
    step(); step(); step();
    chk("bp_hold_row", 64'(row), 64'h0002_0001);
    ready = 1'b1;
    drain();

    // snapshot isolation and START ignored mid-stream
    ready = 1'b0; start = 1'b1;
    step(); start = 1'b0;
    a = {4{16'hFFFF}};
    start = 1'b1;
    step(); start = 1'b0;
    ready = 1'b1;
    drain();

    // START held through the DONE cycle relaunches immediately after
    load_base();
    start = 1'b1; ready = 1'b1;
    step(); step(); step(); step();
    start = 1'b0;
    chk("relaunch_valid", 64'(valid), 64'(1));
    chk("relaunch_idx", 64'(idx), 64'(0));
    drain();

    // async reset between row 0 and row 1
    ready = 1'b0; start = 1'b1;
    step(); start = 1'b0; ready = 1'b1;
    step();
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_row", 64'(row), 64'(0));
    chk("mid_rst_valid", 64'(valid), 64'(0));
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_last", 64'(last), 64'(0));
    chk("mid_rst_done", 64'(done), 64'(0));
    step();
    rst = 1'b0;
    step();
    chk("post_rst_done", 64'(done), 64'(0));
    a[0][0] = 16'h8000; a[0][1] = 16'h7FFF;
    start = 1'b1;
    step(); start = 1'b0;
    chk("post_rst_row0", 64'(row), 64'h7FFF_8000);
    drain();

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      a     = {$urandom, $urandom};
      rev   = 1'($urandom_range(0, 1));
      start = ($urandom_range(0, 3) == 0);
      ready = ($urandom_range(0, 2) != 0);
      step();
    end
    drain();

    // single-row, three 8-bit columns
    e_a[0] = {8'd127, 8'd0, 8'h80};
    e_ready = 1'b0; e_rev = 1'b0; e_start = 1'b1;
    step(); e_start = 1'b0;
    chk("e_valid", 64'(e_valid), 64'(1));
    chk("e_last", 64'(e_last), 64'(1));
    chk("e_row", 64'(e_row), 64'h7F0080);
    chk("e_idx", 64'(e_idx), 64'(0));
    chk("e_busy", 64'(e_busy), 64'(1));
    step();
    chk("e_hold_row", 64'(e_row), 64'h7F0080);
    chk("e_hold_valid", 64'(e_valid), 64'(1));
    e_ready = 1'b1;
    step();
    chk("e_done", 64'(e_done), 64'(1));
    chk("e_valid_off", 64'(e_valid), 64'(0));
    chk("e_last_off", 64'(e_last), 64'(0));
    step();
    chk("e_done_pulse", 64'(e_done), 64'(0));
    e_rev = 1'b1; e_start = 1'b1;
    step(); e_start = 1'b0;
    chk("e_rev_last", 64'(e_last), 64'(1));
    chk("e_rev_row", 64'(e_row), 64'h7F0080);
    step();
    chk("e_rev_done", 64'(e_done), 64'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached before summary");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/array_row_reader.md
# array_row_reader

Streaming reader for 2D signed arrays: captures an NROWS x NCOLS array on a start command and emits it one row per transfer over a valid/ready handshake. It is the read-side counterpart to the row-assign writers: a writer drops whole rows into an array, and this block pulls them back out as a row stream. It sits between array-producing compute entities and row-serial consumers such as FIFOs and output formatters.

## Interface
- NROWS, 2, number of rows (>= 1)
- NCOLS, 2, elements per row (>= 1)
- NBITS, 16, element width, signed
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous, active-high reset
- START  in  1  request a capture and stream; honoured only in IDLE
- REVERSE  in  1  sampled with START; 1 = emit rows NROWS-1 down to 0
- A  in  signed [NBITS] x [NROWS][NCOLS]  source array
- ROW  out  signed [NBITS] x [NCOLS]  current row, registered
- ROW_IDX  out  $clog2(NROWS) (min 1)  source row index of ROW
- ROW_VALID  out  1  ROW, ROW_IDX and ROW_LAST are valid
- ROW_READY  in  1  consumer accepts the row
- ROW_LAST  out  1  ROW is the final row of the stream
- BUSY  out  1  a stream is in progress
- DONE  out  1  single-cycle pulse after the final handshake

## Operation
- States: IDLE and STREAM.
- IDLE, START=1 at an edge:
  - snapshot A into an internal buffer and latch REVERSE;
  - set ptr = 0 (forward) or NROWS-1 (reverse);
  - load ROW/ROW_IDX from the buffer at ptr;
  - ROW_VALID=1, BUSY=1; go to STREAM.
- STREAM, ROW_VALID & ROW_READY at an edge:
  - last row: ROW_VALID=0, ROW_LAST=0, BUSY=0, DONE=1 for one cycle; go to IDLE;
  - otherwise: step ptr by +1 (forward) or -1 (reverse) and load the next row; ROW_VALID stays 1.
- ROW_LAST = ROW_VALID & (ptr == final index), where the final index is NROWS-1 forward and 0 reverse.
- The stream uses only the snapshot; changes on A during STREAM do not affect it.
- START is ignored while BUSY, including in the cycle of the final handshake.
- No bit growth: elements are copied unmodified.

## Timing
- Reset values (asynchronous, immediate): state IDLE; ROW all zeros; ROW_IDX=0; ROW_VALID=0; ROW_LAST=0; BUSY=0; DONE=0; buffer contents don't-care.
- Latency:
  - START sampled at edge k gives first ROW_VALID from edge k.
  - With ROW_READY held high, rows occupy cycles k..k+NROWS-1.
  - DONE is high in cycle k+NROWS.
- Throughput: one row per cycle. Back-to-back streams are separated by at least one IDLE cycle, because START is honoured in the DONE cycle.
- Handshake:
  - While ROW_VALID=1 and ROW_READY=0, ROW, ROW_IDX and ROW_LAST hold stable.
  - ROW_VALID never drops without a handshake.
  - ROW_READY while ROW_VALID=0 has no effect.
- NROWS=1: the first row has ROW_LAST=1; one handshake ends the stream.
- RST mid-stream: the stream is abandoned with no DONE pulse. The next START after RST deasserts starts a fresh stream.

## Structure
- Shared package array_rd_pkg:
  - state enum (IDLE, STREAM);
  - row typedef (logic signed [NBITS-1:0] x [NCOLS]), parameterised via package-level defaults;
  - index-width constant using the $clog2 min-1 rule.
- Optional sub-module array_row_mux: combinational buffer[ptr] selector feeding the ROW register. Everything else lives in one always_ff plus next-state logic.

## Test plan
- Forward, defaults: A={{1,2},{3,4}}, START with ROW_READY=1 -> ROW {1,2} idx0 then {3,4} idx1 with ROW_LAST=1; DONE in the third cycle.
- Reverse: same A with REVERSE=1 -> {3,4} idx1 then {1,2} idx0 with ROW_LAST=1.
- Backpressure: ROW_READY low for 3 cycles on row 0 -> ROW stays {1,2}, ROW_VALID stays 1; DONE only after the second accepted row.
- Snapshot and START ignored: change A to {{-1,-1},{-1,-1}} and pulse START mid-stream -> original rows emitted, no restart. A START in the DONE cycle -> new stream starting the next cycle.
- Async reset: assert RST between row 0 and row 1 -> all outputs zero immediately, no DONE. After release, START -> full stream from row 0.
- Edge sizes: NROWS=1, NCOLS=3, NBITS=8 with row {-128,0,127} -> single row, ROW_LAST=1, values exact.
